// File: rtl/mips_pkg.sv
// mips_pkg: shared load-type codes, register constants and MEM/WB stage record
package mips_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam logic [2:0] LT_WORD  = 3'd0;
   localparam logic [2:0] LT_BYTE  = 3'd1;
   localparam logic [2:0] LT_BYTEU = 3'd2;
   localparam logic [2:0] LT_HALF  = 3'd3;
   localparam logic [2:0] LT_HALFU = 3'd4;
   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic              mem_to_reg;
      logic [2:0]        load_type;
      logic [1:0]        byte_off;
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] read_data;
      logic [ADDR_W-1:0] write_reg;
   } stage_t;
endpackage

// File: rtl/mem_wb_stage_load_align.sv
// load_align: little-endian sub-word extraction/extension and alignment check for loads
module load_align
   import mips_pkg::*;
(
   input  logic [31:0] rd_data,
   input  logic [1:0]  byte_off,
   input  logic [2:0]  load_type,
   output logic [31:0] ext_data,
   output logic        misaligned
);
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   // pick the addressed lane, then extend according to the load type; unknown codes act as a word load
   always_comb begin
      sel_byte   = rd_data[8*byte_off +: 8];
      sel_half   = byte_off[1] ? rd_data[31:16] : rd_data[15:0];
      ext_data   = (load_type == LT_BYTE)  ? {{24{sel_byte[7]}}, sel_byte} :
                   (load_type == LT_BYTEU) ? {24'd0, sel_byte} :
                   (load_type == LT_HALF)  ? {{16{sel_half[15]}}, sel_half} :
                   (load_type == LT_HALFU) ? {16'd0, sel_half} : rd_data;
      misaligned = (load_type == LT_BYTE || load_type == LT_BYTEU) ? 1'b0 :
                   (load_type == LT_HALF || load_type == LT_HALFU) ? byte_off[0] :
                   (byte_off != 2'd0);
   end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register driving the register-file write port, with retire counter
module mem_wb_stage
   import mips_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              mem_valid,
   input  logic              mem_reg_write,
   input  logic              mem_mem_to_reg,
   input  logic [2:0]        mem_load_type,
   input  logic [1:0]        mem_byte_off,
   input  logic [DATA_W-1:0] mem_alu_result,
   input  logic [DATA_W-1:0] mem_read_data,
   input  logic [ADDR_W-1:0] mem_write_reg,
   output logic [ADDR_W-1:0] w_a3,
   output logic [DATA_W-1:0] w_d,
   output logic              w_e3,
   output logic              wb_exc,
   output logic [CNT_W-1:0]  retire_cnt
);
   stage_t            stage_d, stage_q;
   logic [CNT_W-1:0]  cnt_d, cnt_q;
   logic [DATA_W-1:0] ext_data;
   logic              align_bad, misaligned, depart;

   load_align u_align (
      .rd_data   (stage_q.read_data),
      .byte_off  (stage_q.byte_off),
      .load_type (stage_q.load_type),
      .ext_data  (ext_data),
      .misaligned(align_bad)
   );

   // next stage contents (flush beats stall) and retire count of the departing instruction
   always_comb begin
      stage_d    = flush ? '0 : stall ? stage_q :
                   '{valid: mem_valid, reg_write: mem_reg_write, mem_to_reg: mem_mem_to_reg,
                     load_type: mem_load_type, byte_off: mem_byte_off, alu_result: mem_alu_result,
                     read_data: mem_read_data, write_reg: mem_write_reg};
      misaligned = stage_q.mem_to_reg & align_bad;
      depart     = stage_q.valid & (~stall | flush);
      cnt_d      = cnt_q + CNT_W'(depart & ~misaligned);
   end

   // stage register and counter with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stage_q <= '0;
         cnt_q   <= '0;
      end else begin
         stage_q <= stage_d;
         cnt_q   <= cnt_d;
      end
   end

   // writeback port: $0 and misaligned loads never write
   always_comb begin
      w_a3       = stage_q.write_reg;
      w_d        = stage_q.mem_to_reg ? ext_data : stage_q.alu_result;
      w_e3       = stage_q.valid & stage_q.reg_write & ~misaligned & (stage_q.write_reg != REG_ZERO);
      wb_exc     = stage_q.valid & misaligned;
      retire_cnt = cnt_q;
   end
endmodule
